udp_pixel_loader: RTL
=====================

Name: udp_pixel_loader

Overview:
- Consumes the liteeth UDP source stream (one payload byte per beat in data[7:0]) and assembles big-endian 32-bit command words.
- Decodes a 2-bit opcode per word and drives the framebuffer write port of the panel driver: address, pixel data, write enable and brightness.
- Sits between liteeth_core udp_source_* and drive. Replaces the ad-hoc parsing glue in the top level with a checked, port-filtered, self-contained stage.

Parameters:
- LISTEN_PORT, 16'd6454, UDP destination port accepted; all other packets are dropped.
- ADDR_W, 13, width of wr_addr; the framebuffer depth is 2**ADDR_W words.
- BRIGHT_INIT, 4'd15, brightness value after reset.

Ports:
- clock  in  1  system clock (clk_125).
- resetn  in  1  asynchronous active-low reset.
- udp_valid  in  1  liteeth udp_source_valid.
- udp_last  in  1  liteeth udp_source_last.
- udp_ready  out  1  udp_source_ready; tied high internally, the block never back-pressures.
- udp_dst_port  in  16  udp_source_dst_port, sampled on the first beat of a packet.
- udp_length  in  16  udp_source_length, payload bytes, sampled on the first beat.
- udp_data  in  32  udp_source_data; only [7:0] is used.
- wr_en  out  1  one-cycle framebuffer write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  30  pixel data.
- brightness  out  4  brightness value for the driver.
- frame_done  out  1  one-cycle pulse on opcode 2'b10.
- pkt_count  out  16  accepted packets, saturating.
- err_count  out  16  dropped packets, truncated words and out-of-range writes, saturating.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, brightness=BRIGHT_INIT, frame_done=0, pkt_count=0, err_count=0. Internal address=0, byte index=0, FSM in IDLE.
- FSM states:
  - IDLE -> RECV: udp_valid with port match (first beat). Latch udp_length. The byte counter starts at 0.
  - IDLE -> DROP: udp_valid with port mismatch. err_count+1.
  - RECV: each udp_valid beat takes one byte. Shift register is sr <= {sr[23:0], udp_data[7:0]}. The byte counter increments.
    - Bytes with counter >= latched length are discarded, but the packet stays in RECV.
    - Word complete when the byte index reaches 3 and counter < length. Index then wraps to 0.
  - RECV -> IDLE on a beat with udp_last. pkt_count+1. If byte index != 0 at that point (partial word), the partial word is discarded and err_count+1.
  - DROP -> IDLE on udp_last. No outputs change.
  - A single-beat packet (valid and last together in IDLE) is counted and handled in one cycle; a port mismatch counts as a drop.
- Word decode (W = completed word, op = W[31:30]). The word completes in cycle N; effects are registered at N+1:
  - op 00: internal address <= W[29:0]. No write.
  - op 11: if address[29:ADDR_W]==0, then wr_en=1, wr_addr=address[ADDR_W-1:0], wr_data=W[29:0]. Otherwise no write and err_count+1. In both cases address <= address+1, with 30-bit wrap.
  - op 01: brightness <= W[3:0].
  - op 10: frame_done=1 for one cycle.
- Latency: wr_en and frame_done go high exactly 1 cycle after the beat that carries the 4th byte of the word. wr_en is low in every other cycle.
- The address persists across packets. It is cleared only by reset.
- Counters saturate at 16'hFFFF. When two error events coincide in one cycle, err_count increments by 1 only.
- resetn asserted mid-packet: the block returns to IDLE immediately. Remaining beats of that packet are treated as a new packet starting on the next valid beat.

Test Plan:
- Port 6454, 8 bytes 00 00 00 10 C0 00 00 2A, last on byte 8 -> one wr_en, wr_addr=16, wr_data=30'h2A, 1 cycle after byte 8; pkt_count=1.
- Set addr 0x1FFF, then 3 pixel words -> first write at 0x1FFF; next two are suppressed (address 0x2000 and 0x2001 are out of range); err_count=2.
- Port 1234, 8 bytes -> no wr_en; err_count=1; pkt_count=0; the next valid packet on 6454 is processed normally.
- Length 6, last on byte 6 -> one word decoded, partial discarded, err_count=1. Length 4 with 8 beats -> bytes 5-8 ignored, no error.
- Word 40 00 00 07, then 80 00 00 00 -> brightness=7; frame_done pulses for exactly 1 cycle.
- resetn low during byte 2 of a packet -> all outputs return to reset values and brightness=15. A fresh packet after release decodes correctly.

Source files
------------

// File: rtl/udp_pixel_loader.sv
// udp_pixel_loader: assembles big-endian 32-bit command words from the
// liteeth UDP byte stream (port-filtered) and drives the panel framebuffer
// write port, brightness and frame-done strobe.
module udp_pixel_loader #(
    parameter logic [15:0] LISTEN_PORT = 16'd6454,
    parameter int          ADDR_W      = 13,
    parameter logic [3:0]  BRIGHT_INIT = 4'd15
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              udp_valid,
    input  logic              udp_last,
    output logic              udp_ready,
    input  logic [15:0]       udp_dst_port,
    input  logic [15:0]       udp_length,
    input  logic [31:0]       udp_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [29:0]       wr_data,
    output logic [3:0]        brightness,
    output logic              frame_done,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count
);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t      state;
    logic [15:0] len_q;
    logic [15:0] cnt_q;
    logic [1:0]  idx_q;
    logic [23:0] sr_q;
    logic [29:0] addr_q;

    logic        port_ok;
    logic        in_pkt;
    logic [15:0] cur_len;
    logic [15:0] cur_cnt;
    logic [15:0] cnt_next;
    logic [1:0]  cur_idx;
    logic [1:0]  idx_next;
    logic        take;
    logic        word_done;
    logic [31:0] word;
    logic [1:0]  op;
    logic        pkt_end;
    logic        range_ok;
    logic        err_evt;
    logic        unused_data;

    // The stream is never back-pressured; only the low payload byte is used.
    assign udp_ready   = 1'b1;
    assign unused_data = ^udp_data[31:8];

    // Beat qualification. In IDLE the first beat of an accepted packet is
    // processed with a fresh length/counter/index so single-beat packets work.
    always_comb begin
        port_ok   = (udp_dst_port == LISTEN_PORT);
        in_pkt    = udp_valid && ((state == RECV) || ((state == IDLE) && port_ok));
        cur_len   = (state == IDLE) ? udp_length : len_q;
        cur_cnt   = (state == IDLE) ? 16'd0 : cnt_q;
        cur_idx   = (state == IDLE) ? 2'd0 : idx_q;
        cnt_next  = (cur_cnt == 16'hFFFF) ? cur_cnt : cur_cnt + 16'd1;
        take      = in_pkt && (cur_cnt < cur_len);
        word_done = take && (cur_idx == 2'd3);
        idx_next  = take ? cur_idx + 2'd1 : cur_idx;
        word      = {sr_q, udp_data[7:0]};
        op        = word[31:30];
        pkt_end   = in_pkt && udp_last;
        range_ok  = ((addr_q >> ADDR_W) == 30'd0);
        // Drop, truncated word and out-of-range write are merged so that
        // coincident events count once.
        err_evt   = (udp_valid && (state == IDLE) && !port_ok)
                  || (pkt_end && (idx_next != 2'd0))
                  || (word_done && (op == 2'b11) && !range_ok);
    end

    // Packet FSM and byte assembly.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            len_q <= 16'd0;
            cnt_q <= 16'd0;
            idx_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            if (in_pkt) begin
                len_q <= cur_len;
                cnt_q <= cnt_next;
                idx_q <= idx_next;
                if (take)
                    sr_q <= {sr_q[15:0], udp_data[7:0]};
            end
            case (state)
                IDLE: begin
                    if (udp_valid && !udp_last)
                        state <= port_ok ? RECV : DROP;
                end
                RECV: begin
                    if (udp_valid && udp_last)
                        state <= IDLE;
                end
                DROP: begin
                    if (udp_valid && udp_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word decode; effects appear the cycle after the completing byte.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 30'd0;
            brightness <= BRIGHT_INIT;
            frame_done <= 1'b0;
            addr_q     <= 30'd0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (word_done) begin
                case (op)
                    2'b00: addr_q <= word[29:0];
                    2'b11: begin
                        if (range_ok) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr_q[ADDR_W-1:0];
                            wr_data <= word[29:0];
                        end
                        addr_q <= addr_q + 30'd1;
                    end
                    2'b01: brightness <= word[3:0];
                    default: frame_done <= 1'b1;
                endcase
            end
        end
    end

    // Saturating packet and error counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_count <= 16'd0;
            err_count <= 16'd0;
        end else begin
            if (pkt_end && (pkt_count != 16'hFFFF))
                pkt_count <= pkt_count + 16'd1;
            if (err_evt && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end

endmodule
